// File: rtl/aq_pkg.sv
// Shared state encoding, default thresholds and a width helper for the
// multi-room air-quality controller.
package aq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PURIFY   = 2'd1,
        ST_HUMIDIFY = 2'd2
    } aq_state_e;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_PUR_ON   = 100;
    localparam int DEF_PUR_OFF  = 90;
    localparam int DEF_HUM_ON   = 30;
    localparam int DEF_HUM_OFF  = 40;
    localparam int DEF_CONFIRM  = 3;
    localparam int DEF_MIN_ON   = 8;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/aq_room_ctrl.sv
// One room: IDLE/PURIFY/HUMIDIFY FSM with confirm counters and a
// minimum-on hold timer. Acts on a sample only when hit is high.
module aq_room_ctrl
    import aq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PUR_ON  = DEF_PUR_ON,
    parameter int PUR_OFF = DEF_PUR_OFF,
    parameter int HUM_ON  = DEF_HUM_ON,
    parameter int HUM_OFF = DEF_HUM_OFF,
    parameter int CONFIRM = DEF_CONFIRM,
    parameter int MIN_ON  = DEF_MIN_ON
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit,
    input  logic [WIDTH-1:0] sample_value,
    output logic             purifier,
    output logic             humidifier
);

    localparam int CNT_W  = cnt_width(CONFIRM);
    localparam int HOLD_W = cnt_width(MIN_ON);

    localparam logic [WIDTH-1:0]  PUR_ON_V  = WIDTH'(PUR_ON);
    localparam logic [WIDTH-1:0]  PUR_OFF_V = WIDTH'(PUR_OFF);
    localparam logic [WIDTH-1:0]  HUM_ON_V  = WIDTH'(HUM_ON);
    localparam logic [WIDTH-1:0]  HUM_OFF_V = WIDTH'(HUM_OFF);
    localparam logic [CNT_W-1:0]  CONFIRM_V = CNT_W'(CONFIRM);
    localparam logic [HOLD_W-1:0] MIN_ON_V  = HOLD_W'(MIN_ON);

    aq_state_e         state_q, state_d;
    logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]  lo_cnt_q, lo_cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [CNT_W-1:0] hi_inc, lo_inc;
    assign hi_inc = hi_cnt_q + CNT_W'(1);
    assign lo_inc = lo_cnt_q + CNT_W'(1);

    // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        hi_cnt_d = hi_cnt_q;
        lo_cnt_d = lo_cnt_q;
        hold_d   = (hold_q != '0) ? hold_q - HOLD_W'(1) : hold_q;

        if (hit) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (sample_value >= PUR_ON_V) begin
                        lo_cnt_d = '0;
                        if (hi_inc == CONFIRM_V) begin
                            state_d  = ST_PURIFY;
                            hold_d   = MIN_ON_V;
                            hi_cnt_d = '0;
                        end else begin
                            hi_cnt_d = hi_inc;
                        end
                    end else if (sample_value <= HUM_ON_V) begin
                        hi_cnt_d = '0;
                        if (lo_inc == CONFIRM_V) begin
                            state_d  = ST_HUMIDIFY;
                            hold_d   = MIN_ON_V;
                            lo_cnt_d = '0;
                        end else begin
                            lo_cnt_d = lo_inc;
                        end
                    end else begin
                        hi_cnt_d = '0;
                        lo_cnt_d = '0;
                    end
                end
                ST_PURIFY: begin
                    if (sample_value < PUR_OFF_V && hold_q == '0) state_d = ST_IDLE;
                end
                ST_HUMIDIFY: begin
                    if (sample_value > HUM_OFF_V && hold_q == '0) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            hi_cnt_q <= '0;
            lo_cnt_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            hi_cnt_q <= hi_cnt_d;
            lo_cnt_q <= lo_cnt_d;
            hold_q   <= hold_d;
        end
    end

    // Decoded straight from state so reset drops the enables without a clock.
    assign purifier   = (state_q == ST_PURIFY);
    assign humidifier = (state_q == ST_HUMIDIFY);

endmodule

// File: rtl/air_quality_ctrl.sv
// Multi-room air-quality controller: decodes the time-multiplexed sample
// stream into per-room hits and flags samples addressed to absent rooms.
module air_quality_ctrl
    import aq_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int PUR_ON   = DEF_PUR_ON,
    parameter int PUR_OFF  = DEF_PUR_OFF,
    parameter int HUM_ON   = DEF_HUM_ON,
    parameter int HUM_OFF  = DEF_HUM_OFF,
    parameter int CONFIRM  = DEF_CONFIRM,
    parameter int MIN_ON   = DEF_MIN_ON
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [3:0]          sample_chan,
    input  logic [WIDTH-1:0]    sample_value,
    output logic [CHANNELS-1:0] purifier,
    output logic [CHANNELS-1:0] humidifier,
    output logic                err_chan
);

    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("air_quality_ctrl: CHANNELS must be in 1..16");
    end
    if (CONFIRM < 1) begin : g_bad_confirm
        $error("air_quality_ctrl: CONFIRM must be at least 1");
    end
    if (!(HUM_ON < HUM_OFF && HUM_OFF <= PUR_OFF && PUR_OFF < PUR_ON)) begin : g_bad_thresholds
        $error("air_quality_ctrl: thresholds must satisfy HUM_ON < HUM_OFF <= PUR_OFF < PUR_ON");
    end

    // Extra bit keeps the compare meaningful when CHANNELS == 16.
    logic chan_ok;
    assign chan_ok = ({1'b0, sample_chan} < 5'(CHANNELS));

    logic err_chan_q, err_chan_d;
    assign err_chan_d = sample_valid && !chan_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_chan_q <= 1'b0;
        else      err_chan_q <= err_chan_d;
    end

    assign err_chan = err_chan_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_room
        logic hit;
        assign hit = sample_valid && chan_ok && (sample_chan == 4'(c));

        aq_room_ctrl #(
            .WIDTH   (WIDTH),
            .PUR_ON  (PUR_ON),
            .PUR_OFF (PUR_OFF),
            .HUM_ON  (HUM_ON),
            .HUM_OFF (HUM_OFF),
            .CONFIRM (CONFIRM),
            .MIN_ON  (MIN_ON)
        ) u_room (
            .clk          (clk),
            .rst          (rst),
            .hit          (hit),
            .sample_value (sample_value),
            .purifier     (purifier[c]),
            .humidifier   (humidifier[c])
        );
    end

endmodule

// File: tb/tb_air_quality_ctrl.sv
// Directed bench for air_quality_ctrl with hand-computed expectations
// (defaults: CHANNELS=4, CONFIRM=3, MIN_ON=8).
module tb_air_quality_ctrl;

    logic       clk;
    logic       rst;
    logic       sample_valid;
    logic [3:0] sample_chan;
    logic [7:0] sample_value;
    logic [3:0] purifier;
    logic [3:0] humidifier;
    logic       err_chan;

    int n_tests = 0;
    int n_fail  = 0;

    air_quality_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_chan  (sample_chan),
        .sample_value (sample_value),
        .purifier     (purifier),
        .humidifier   (humidifier),
        .err_chan     (err_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one sample at a falling edge; returns at the next falling edge,
    // where the effect of the sampling rising edge is visible.
    task automatic send(input logic [3:0] ch, input logic [7:0] val);
        sample_valid = 1'b1;
        sample_chan  = ch;
        sample_value = val;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_chan  = '0;
        sample_value = '0;
        #3 rst = 1'b0;
        #1;
        check("reset_pur", 32'(purifier), 32'h0);
        check("reset_hum", 32'(humidifier), 32'h0);
        check("reset_err", 32'(err_chan), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Debounce: a mid-band sample breaks the run.
        send(4'd0, 8'd120);
        send(4'd0, 8'd50);
        send(4'd0, 8'd120);
        send(4'd0, 8'd120);
        check("debounce_hold", 32'(purifier[0]), 32'h0);
        send(4'd0, 8'd120);
        check("debounce_on", 32'(purifier), 32'h1);

        // Asynchronous reset mid-operation, checked before the next rising edge.
        #2 rst = 1'b0;
        #1;
        check("async_rst_pur", 32'(purifier), 32'h0);
        check("async_rst_hum", 32'(humidifier), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        send(4'd0, 8'd120);
        send(4'd0, 8'd120);
        check("post_rst_2samples", 32'(purifier[0]), 32'h0);
        send(4'd0, 8'd120);
        check("post_rst_3samples", 32'(purifier[0]), 32'h1);

        // Hysteresis and min-on on room 1; 100 is exactly the turn-on threshold.
        do_reset();
        send(4'd1, 8'd100);
        send(4'd1, 8'd100);
        send(4'd1, 8'd100);
        check("ch1_on_at_threshold", 32'(purifier), 32'h2);
        idle(1);
        send(4'd1, 8'd85);
        check("ch1_hold_active", 32'(purifier[1]), 32'h1);
        idle(8);
        send(4'd1, 8'd95);
        check("ch1_hysteresis", 32'(purifier[1]), 32'h1);
        send(4'd1, 8'd90);
        check("ch1_at_pur_off", 32'(purifier[1]), 32'h1);
        send(4'd1, 8'd85);
        check("ch1_release", 32'(purifier[1]), 32'h0);

        // Below-threshold values never count.
        send(4'd1, 8'd99);
        send(4'd1, 8'd99);
        send(4'd1, 8'd99);
        check("ch1_99_no_count", 32'(purifier[1]), 32'h0);

        // Exact min-on edge: release at hold==1 ignored, at hold==0 honoured.
        send(4'd3, 8'd30);
        send(4'd3, 8'd30);
        send(4'd3, 8'd30);
        check("ch3_hum_on_threshold", 32'(humidifier), 32'h8);
        idle(7);
        send(4'd3, 8'd41);
        check("ch3_hold_last_cycle", 32'(humidifier[3]), 32'h1);
        send(4'd3, 8'd40);
        check("ch3_at_hum_off", 32'(humidifier[3]), 32'h1);
        send(4'd3, 8'd41);
        check("ch3_release", 32'(humidifier[3]), 32'h0);

        // Interlock on room 2.
        do_reset();
        send(4'd2, 8'd20);
        send(4'd2, 8'd20);
        send(4'd2, 8'd20);
        check("ch2_hum_on", 32'(humidifier), 32'h4);
        check("ch2_pur_off", 32'(purifier), 32'h0);
        idle(10);
        send(4'd2, 8'd120);
        check("ch2_exit_hum", 32'(humidifier[2]), 32'h0);
        check("ch2_exit_no_pur", 32'(purifier[2]), 32'h0);
        send(4'd2, 8'd120);
        send(4'd2, 8'd120);
        check("ch2_exit_not_counted", 32'(purifier[2]), 32'h0);
        send(4'd2, 8'd120);
        check("ch2_pur_on", 32'(purifier[2]), 32'h1);
        check("ch2_interlock", 32'(purifier[2] & humidifier[2]), 32'h0);

        // Isolation: interleaved back-to-back samples to rooms 0 and 3.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(4'd0, 8'd120);
            send(4'd3, 8'd20);
        end
        check("iso_pur", 32'(purifier), 32'h1);
        check("iso_hum", 32'(humidifier), 32'h8);

        // Bad channels: 5 and the boundary 4 are dropped and flagged.
        do_reset();
        check("err_idle", 32'(err_chan), 32'h0);
        for (int i = 0; i < 5; i++) begin
            send(4'd5, 8'd200);
            check($sformatf("err_pulse_%0d", i), 32'(err_chan), 32'h1);
            check($sformatf("err_outs_%0d", i), 32'({purifier, humidifier}), 32'h0);
        end
        idle(1);
        check("err_clears", 32'(err_chan), 32'h0);
        send(4'd4, 8'd20);
        send(4'd4, 8'd20);
        send(4'd4, 8'd20);
        check("err_chan4", 32'(err_chan), 32'h1);
        check("err_chan4_outs", 32'({purifier, humidifier}), 32'h0);
        send(4'd1, 8'd120);
        check("err_no_leak_ch1", 32'(purifier), 32'h0);
        check("good_chan_no_err", 32'(err_chan), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
